// File: rtl/br_tag_ctrl.sv
// br_tag_ctrl: circular branch-tag allocator with mispredict rollback and a
// held fetch-redirect handshake. Ports: i_clk/i_rst (async, active-high),
// i_alloc/o_alloc_ok/o_brmask/o_full (dispatch), i_commit_br (retire),
// i_brkill/i_pc/i_valid (branch execute), o_redirect/o_redirect_pc/
// i_redirect_ack (fetch), o_stall (dispatch stall).
// Optional macro BR_TAG_STATS_EN adds o_mispred_cnt (mispredict counter).
module br_tag_ctrl #(
    parameter int WIDTH_BRM = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_alloc,
    output logic                   o_alloc_ok,
    output logic [WIDTH_BRM-1:0]   o_brmask,
    output logic                   o_full,
    input  logic                   i_commit_br,
    input  logic [(1<<WIDTH_BRM)-1:0] i_brkill,
    input  logic [31:0]            i_pc,
    input  logic                   i_valid,
    output logic                   o_redirect,
    output logic [31:0]            o_redirect_pc,
    input  logic                   i_redirect_ack,
    output logic                   o_stall
`ifdef BR_TAG_STATS_EN
    ,
    output logic [31:0]            o_mispred_cnt
`endif
);

    localparam int N = 1 << WIDTH_BRM;

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t               state_q;
    logic [WIDTH_BRM-1:0] cur_q;
    logic [WIDTH_BRM-1:0] oldest_q;
    logic [31:0]          pc_q;
    logic [WIDTH_BRM-1:0] count;
    logic [WIDTH_BRM-1:0] rb_tag_d;
    logic                 kill_now;
    logic                 full;

    assign count    = cur_q - oldest_q;
    assign full     = (count == WIDTH_BRM'(N - 1));
    assign kill_now = i_valid & (|i_brkill);

    assign o_alloc_ok    = i_alloc & ~full & (state_q == IDLE) & ~kill_now;
    assign o_full        = full;
    assign o_stall       = full | (state_q != IDLE);
    assign o_brmask      = cur_q;
    assign o_redirect    = (state_q == REDIR);
    assign o_redirect_pc = pc_q;

    // The killed run ends at the newest tag; the surviving tag is the
    // clear bit sitting just below the run's lowest (circular) member.
    always_comb begin
        rb_tag_d = cur_q;
        for (int t = 0; t < N; t++) begin
            if (!i_brkill[t] && i_brkill[(t + 1) % N]) begin
                rb_tag_d = WIDTH_BRM'(t);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            oldest_q <= '0;
            pc_q     <= '0;
        end else begin
            if (kill_now) begin
                cur_q <= rb_tag_d;
            end else if (o_alloc_ok) begin
                cur_q <= cur_q + 1'b1;
            end

            if (i_commit_br && (count != '0)) begin
                oldest_q <= oldest_q + 1'b1;
            end

            // A new kill outranks a concurrent ack: fetch must see the
            // younger corrected PC.
            unique case (state_q)
                IDLE: begin
                    if (kill_now) begin
                        state_q <= REDIR;
                        pc_q    <= i_pc;
                    end
                end
                REDIR: begin
                    if (kill_now) begin
                        pc_q <= i_pc;
                    end else if (i_redirect_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BR_TAG_STATS_EN
    logic [31:0] mispred_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mispred_q <= '0;
        end else if (kill_now) begin
            mispred_q <= mispred_q + 32'd1;
        end
    end

    assign o_mispred_cnt = mispred_q;
`endif

endmodule

// File: tb/tb_br_tag_ctrl.sv
// Directed bench for br_tag_ctrl with a tag-arithmetic reference model
// checked every negedge, plus hand-computed literal expectations.
module tb_br_tag_ctrl;

    localparam int W = 4;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_alloc = 1'b0;
    logic        i_commit_br = 1'b0;
    logic [15:0] i_brkill = '0;
    logic [31:0] i_pc = '0;
    logic        i_valid = 1'b0;
    logic        i_redirect_ack = 1'b0;
    logic        o_alloc_ok;
    logic [3:0]  o_brmask;
    logic        o_full;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_stall;
`ifdef BR_TAG_STATS_EN
    logic [31:0] o_mispred_cnt;
`endif

    br_tag_ctrl #(.WIDTH_BRM(W)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_alloc        (i_alloc),
        .o_alloc_ok     (o_alloc_ok),
        .o_brmask       (o_brmask),
        .o_full         (o_full),
        .i_commit_br    (i_commit_br),
        .i_brkill       (i_brkill),
        .i_pc           (i_pc),
        .i_valid        (i_valid),
        .o_redirect     (o_redirect),
        .o_redirect_pc  (o_redirect_pc),
        .i_redirect_ack (i_redirect_ack),
        .o_stall        (o_stall)
`ifdef BR_TAG_STATS_EN
        ,
        .o_mispred_cnt  (o_mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference model: tags as plain integers modulo N.
    int          m_cur, m_old, m_kills;
    bit          m_redir;
    logic [31:0] m_pc;

    // Walk backwards from the lowest killed tag through the run; the tag
    // just before the run is the surviving newest branch.
    function automatic int rollback(input logic [15:0] k);
        int j;
        j = 0;
        for (int i = 0; i < N; i++) begin
            if (k[i]) begin
                j = i;
                break;
            end
        end
        for (int s = 0; s < N; s++) begin
            if (k[(j + N - 1) % N]) j = (j + N - 1) % N;
            else break;
        end
        return (j + N - 1) % N;
    endfunction

    function automatic int m_count();
        return (m_cur - m_old + N) % N;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cur = 0; m_old = 0; m_kills = 0;
            m_redir = 0; m_pc = '0;
        end else begin
            bit kill, ok;
            int cnt;
            kill = i_valid && (i_brkill != 0);
            cnt  = m_count();
            ok   = i_alloc && cnt != N - 1 && !m_redir && !kill;
            if (i_commit_br && cnt != 0) m_old = (m_old + 1) % N;
            if (kill) begin
                m_cur = rollback(i_brkill);
                m_redir = 1; m_pc = i_pc; m_kills++;
            end else begin
                if (ok) m_cur = (m_cur + 1) % N;
                if (m_redir && i_redirect_ack) m_redir = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            bit kill, exp_full;
            kill = i_valid && (i_brkill != 0);
            exp_full = (m_count() == N - 1);
            chk("m_brmask", 32'(o_brmask), 32'(m_cur));
            chk("m_full", 32'(o_full), 32'(exp_full));
            chk("m_stall", 32'(o_stall), 32'(exp_full | m_redir));
            chk("m_redirect", 32'(o_redirect), 32'(m_redir));
            chk("m_redir_pc", o_redirect_pc, m_pc);
            chk("m_alloc_ok", 32'(o_alloc_ok),
                32'(i_alloc && !exp_full && !m_redir && !kill));
`ifdef BR_TAG_STATS_EN
            chk("m_mispred", o_mispred_cnt, 32'(m_kills));
`endif
        end
    end

    task automatic step(input bit a, input bit c, input logic [15:0] k,
                        input logic [31:0] p, input bit v, input bit ack);
        i_alloc = a; i_commit_br = c; i_brkill = k;
        i_pc = p; i_valid = v; i_redirect_ack = ack;
        @(posedge clk);
        #1;
        i_alloc = 0; i_commit_br = 0; i_brkill = '0;
        i_pc = '0; i_valid = 0; i_redirect_ack = 0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        #3;
        chk("rst_brmask", 32'(o_brmask), 0);
        chk("rst_redirect", 32'(o_redirect), 0);
        chk("rst_pc", o_redirect_pc, 0);
        chk("rst_full", 32'(o_full), 0);
        chk("rst_stall", 32'(o_stall), 0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Three allocations.
        step(1, 0, 0, 0, 0, 0);
        chk("alloc1", 32'(o_brmask), 1);
        step(1, 0, 0, 0, 0, 0);
        chk("alloc2", 32'(o_brmask), 2);
        step(1, 0, 0, 0, 0, 0);
        chk("alloc3", 32'(o_brmask), 3);
        chk("alloc3_full", 32'(o_full), 0);

        // Fill to N-1 in flight.
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0);
        chk("fill_brmask", 32'(o_brmask), 15);
        chk("fill_full", 32'(o_full), 1);
        chk("fill_stall", 32'(o_stall), 1);
        i_alloc = 1; #1;
        chk("full_alloc_ok", 32'(o_alloc_ok), 0);
        i_alloc = 0;
        step(1, 0, 0, 0, 0, 0);
        chk("full_rejected", 32'(o_brmask), 15);
        step(0, 1, 0, 0, 0, 0);
        chk("commit_unfull", 32'(o_full), 0);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap", 32'(o_brmask), 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("alloc_commit", 32'(o_brmask), 1);
        chk("alloc_commit_full", 32'(o_full), 0);

        // cur=6, oldest=2; kill 0x0070.
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 16'h0070, 32'h1000, 1, 0);
        chk("kill_brmask", 32'(o_brmask), 3);
        chk("kill_redirect", 32'(o_redirect), 1);
        chk("kill_pc", o_redirect_pc, 32'h1000);
        chk("kill_stall", 32'(o_stall), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("redir_held", 32'(o_redirect), 1);
        i_alloc = 1; #1;
        chk("redir_alloc_ok", 32'(o_alloc_ok), 0);
        i_alloc = 0;
        step(0, 0, 0, 0, 0, 1);
        chk("ack_redirect", 32'(o_redirect), 0);
        chk("ack_stall", 32'(o_stall), 0);
        chk("ack_brmask", 32'(o_brmask), 3);
        step(0, 0, 0, 32'h5000, 1, 0);
        chk("goodpred_redir", 32'(o_redirect), 0);

        // Wrap kill: cur=1, oldest=12.
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
        chk("pre_wrap_brmask", 32'(o_brmask), 1);
        step(0, 0, 0, 32'h6000, 1, 0);
        step(0, 0, 0, 32'h7000, 1, 0);
        chk("goodpred_brmask", 32'(o_brmask), 1);
        step(0, 0, 16'hC003, 32'h3000, 1, 0);
        chk("wrap_kill", 32'(o_brmask), 13);

        // Kill + ack + alloc + commit while in REDIR.
        i_alloc = 1; i_commit_br = 1; i_brkill = 16'h0008;
        i_pc = 32'h2000; i_valid = 1; i_redirect_ack = 1;
        #1;
        chk("kill_alloc_ok", 32'(o_alloc_ok), 0);
        step(1, 1, 16'h0008, 32'h2000, 1, 1);
        chk("rekill_redirect", 32'(o_redirect), 1);
        chk("rekill_pc", o_redirect_pc, 32'h2000);
        chk("rekill_brmask", 32'(o_brmask), 2);
        step(0, 0, 16'h0004, 32'h4000, 1, 0);
        chk("kill3_brmask", 32'(o_brmask), 1);
`ifdef BR_TAG_STATS_EN
        chk("mispred_cnt", o_mispred_cnt, 3);
`endif

        // Asynchronous reset while redirecting.
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_brmask", 32'(o_brmask), 0);
        chk("arst_redirect", 32'(o_redirect), 0);
        chk("arst_pc", o_redirect_pc, 0);
        chk("arst_full", 32'(o_full), 0);
        chk("arst_stall", 32'(o_stall), 0);
`ifdef BR_TAG_STATS_EN
        chk("arst_mispred", o_mispred_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/br_tag_ctrl.md
# br_tag_ctrl

Branch-tag controller and front-end redirect unit for the out-of-order core. Allocates circular branch tags at dispatch and supplies the current tag (`o_brmask`) that dispatch attaches to every instruction and execute consumes. Consumes the branch-execute results (kill vector, corrected PC, valid). On a mispredict it rolls the allocation pointer back and drives a held redirect handshake to fetch. Frees tags in order at branch commit.

## Interface
- `WIDTH_BRM`, 4: tag width; N = 2**WIDTH_BRM tags.
- `i_clk`  in  1  clock; all state on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_alloc`  in  1  dispatch presents a branch this cycle.
- `o_alloc_ok`  out  1  allocation accepted (comb: `i_alloc & ~o_full & state==IDLE & ~kill_now`).
- `o_brmask`  out  WIDTH_BRM  current tag `cur`; after an accepted alloc the branch owns `cur+1`.
- `o_full`  out  1  `count == N-1`.
- `i_commit_br`  in  1  oldest in-flight branch retires.
- `i_brkill`  in  N  kill vector from branch execute; tags in (branch tag, newest] set.
- `i_pc`  in  32  corrected PC from branch execute.
- `i_valid`  in  1  branch-execute result valid.
- `o_redirect`  out  1  redirect request to fetch; held until acked.
- `o_redirect_pc`  out  32  redirect target.
- `i_redirect_ack`  in  1  fetch accepts redirect.
- `o_stall`  out  1  dispatch stall: `o_full | state!=IDLE`.

## Operation
- State: `cur`, `oldest` (WIDTH_BRM each), FSM {IDLE, REDIR}. `count = (cur - oldest) mod N`.
- `kill_now = i_valid & |i_brkill`.
- Alloc accepted: `cur <= cur + 1` (mod N wrap, 15 -> 0 for WIDTH_BRM=4).
- Commit: if `count != 0`, `oldest <= oldest + 1`; commit with `count == 0` ignored.
- Rollback on `kill_now`: find unique t with `i_brkill[t]==0` and `i_brkill[(t+1) mod N]==1`; `cur <= t`. Vector contiguous in circular order, non-empty, not all-ones; other patterns are illegal input.
- Redirect: on `kill_now`, `o_redirect_pc <= i_pc`, state -> REDIR. In REDIR `o_redirect=1`; `i_redirect_ack` -> IDLE.
- Kill in REDIR: PC overwritten, rollback re-applied, stays REDIR; kill with ack in same cycle: new kill wins, stays REDIR.
- Simultaneous alloc + commit: both applied, count unchanged. Simultaneous kill + alloc: alloc rejected (`o_alloc_ok=0`). Simultaneous kill + commit: both applied (commit moves `oldest`, rollback sets `cur`).
- `i_valid` with all-zero `i_brkill`: correctly predicted branch, no action.

## Timing
- Reset: `cur=0`, `oldest=0`, state IDLE, `o_redirect=0`, `o_redirect_pc=0`, `o_full=0`, `o_stall=0`.
- `o_brmask` updates the cycle after an accepted alloc or a kill.
- Kill at cycle k -> `o_redirect=1` and `o_redirect_pc` valid from cycle k+1, held until the cycle after ack.
- `o_alloc_ok`, `o_full`, `o_stall` are combinational from current state and inputs; no input-to-register bypass on `o_brmask`.
- Reset mid-REDIR: immediate return to reset values, redirect dropped.

## Configuration
- `BR_TAG_STATS_EN` defined: adds output `o_mispred_cnt` (32 bits, reset 0), incremented once per cycle in which `kill_now` is set, wraps at 2^32. Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then 3 allocs, no commits -> `o_brmask` 0->1->2->3, count 3, `o_full=0`.
- 15 allocs (WIDTH_BRM=4) -> `o_full=1`, 16th `i_alloc` gets `o_alloc_ok=0`. One commit -> `o_full=0`, next alloc accepted, `cur` wraps 15->0.
- `cur=6`, `oldest=2`, kill 0x0070 with `i_pc=0x1000` -> next cycle `o_brmask=3`, `o_redirect=1`, `o_redirect_pc=0x1000`. Ack 2 cycles later -> `o_redirect=0`, state IDLE, `o_stall=0`.
- Wrap kill: `cur=1`, `oldest=12`, kill 0xC003 -> `o_brmask=13`.
- In REDIR, second kill 0x0008 with `i_pc=0x2000` together with ack -> stays REDIR, `o_redirect_pc=0x2000`, `o_brmask=2`. Same-cycle kill and alloc -> `o_alloc_ok=0`, `cur` unaffected by alloc.
- `BR_TAG_STATS_EN`: 3 kills plus 2 valid zero-kill results -> `o_mispred_cnt=3`. `i_rst` pulse mid-REDIR -> all outputs at reset values asynchronously.
